// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator output path.
// Holds the omap_biu FSM state encoding and the beat/word geometry
// used by both the bus interface unit and its beat packer.
package acc_pkg;

  // Layer-write sequencing states of omap_biu
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } omap_state_e;

  localparam int OMAP_BEAT_W         = 64;
  localparam int OMAP_WORD_W         = 32;
  localparam int OMAP_BYTES_PER_BEAT = 8;

endpackage

// File: rtl/omap_biu_if.sv
// Bus bundle for omap_biu.
// Carries the map_merger -> omap_biu word stream (data/vld/rdy) and the
// omap_biu -> memory write request channel (vld/addr/data/strb/rdy).
// Modports:
//   slave  - the omap_biu view: consumes words, issues write requests
//   master - the environment view: produces words, accepts write requests
interface omap_biu_if #(
  parameter int ADDR_W = 32
);
  import acc_pkg::*;

  logic [OMAP_WORD_W-1:0]         map_merger2omap_biu_data;
  logic                           map_merger2omap_biu_vld;
  logic                           map_merger2omap_biu_rdy;
  logic                           omap_biu2mem_wr_vld;
  logic [ADDR_W-1:0]              omap_biu2mem_wr_addr;
  logic [OMAP_BEAT_W-1:0]         omap_biu2mem_wr_data;
  logic [OMAP_BYTES_PER_BEAT-1:0] omap_biu2mem_wr_strb;
  logic                           omap_biu2mem_wr_rdy;

  modport slave (
    input  map_merger2omap_biu_data,
    input  map_merger2omap_biu_vld,
    output map_merger2omap_biu_rdy,
    output omap_biu2mem_wr_vld,
    output omap_biu2mem_wr_addr,
    output omap_biu2mem_wr_data,
    output omap_biu2mem_wr_strb,
    input  omap_biu2mem_wr_rdy
  );

  modport master (
    output map_merger2omap_biu_data,
    output map_merger2omap_biu_vld,
    input  map_merger2omap_biu_rdy,
    input  omap_biu2mem_wr_vld,
    input  omap_biu2mem_wr_addr,
    input  omap_biu2mem_wr_data,
    input  omap_biu2mem_wr_strb,
    output omap_biu2mem_wr_rdy
  );

endinterface

// File: rtl/omap_beat_packer.sv
// Pairs accepted 32-bit omap words into 64-bit memory beats.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   accept     a word is transferred this cycle
//   last       the transferred word is the final word of the layer
//   word       the transferred word
//   beat_load  a complete beat is formed this cycle
//   beat_data  formed beat; the earlier word sits in [31:0]
//   beat_strb  byte strobes for the formed beat
module omap_beat_packer
  import acc_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           accept,
  input  logic                           last,
  input  logic [OMAP_WORD_W-1:0]         word,
  output logic                           beat_load,
  output logic [OMAP_BEAT_W-1:0]         beat_data,
  output logic [OMAP_BYTES_PER_BEAT-1:0] beat_strb
);

  logic [OMAP_WORD_W-1:0] low_word;
  logic                   half_full;

  // Park the first word of a pair; the second word (or a lone final
  // word) completes the beat and empties the low half again.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_word  <= '0;
      half_full <= 1'b0;
    end else if (accept) begin
      if (half_full) begin
        half_full <= 1'b0;
      end else if (!last) begin
        low_word  <= word;
        half_full <= 1'b1;
      end
    end
  end

  // An odd final word goes out alone in the low half with only the
  // lower four byte lanes enabled.
  always_comb begin
    beat_load = accept & (half_full | last);
    if (half_full) begin
      beat_data = {word, low_word};
      beat_strb = '1;
    end else begin
      beat_data = {{OMAP_WORD_W{1'b0}}, word};
      beat_strb = {{(OMAP_BYTES_PER_BEAT/2){1'b0}}, {(OMAP_BYTES_PER_BEAT/2){1'b1}}};
    end
  end

endmodule

// File: rtl/omap_biu.sv
// Output-map bus interface unit: consumes merged omap words from the
// map_merger stream, packs pairs into 64-bit beats and writes them to
// sequential memory addresses from a configured base, then pulses done.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   cfg_start       1-cycle pulse starting a layer write (IDLE only)
//   cfg_base_addr   byte address of the first beat (8-byte aligned)
//   cfg_word_num    number of 32-bit words in the layer
//   bus             omap_biu_if.slave: word stream in, write requests out
//   omap_biu_busy   high from start until done
//   omap_biu_done   1-cycle pulse when the layer is complete
module omap_biu
  import acc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_word_num,
  omap_biu_if.slave         bus,
  output logic              omap_biu_busy,
  output logic              omap_biu_done
);

  omap_state_e                    state;
  logic [CNT_W-1:0]               word_cnt;
  logic [ADDR_W-1:0]              addr_next;
  logic                           in_rdy;
  logic                           accept;
  logic                           last;
  logic                           wr_fire;
  logic                           beat_load;
  logic [OMAP_BEAT_W-1:0]         beat_data;
  logic [OMAP_BYTES_PER_BEAT-1:0] beat_strb;

  // A word may only be taken when the output register is free or is
  // being emptied this very cycle, so no beat is ever overwritten.
  assign in_rdy  = (state == ST_RUN) & (~bus.omap_biu2mem_wr_vld | bus.omap_biu2mem_wr_rdy);
  assign accept  = bus.map_merger2omap_biu_vld & in_rdy;
  assign last    = (word_cnt == CNT_W'(1));
  assign wr_fire = bus.omap_biu2mem_wr_vld & bus.omap_biu2mem_wr_rdy;

  assign bus.map_merger2omap_biu_rdy = in_rdy;

  omap_beat_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .last      (last),
    .word      (bus.map_merger2omap_biu_data),
    .beat_load (beat_load),
    .beat_data (beat_data),
    .beat_strb (beat_strb)
  );

  // Layer sequencer plus output register. A new beat load wins over a
  // concurrent handshake so back-to-back beats stay valid; a lone
  // handshake clears the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= ST_IDLE;
      word_cnt                 <= '0;
      addr_next                <= '0;
      omap_biu_busy            <= 1'b0;
      omap_biu_done            <= 1'b0;
      bus.omap_biu2mem_wr_vld  <= 1'b0;
      bus.omap_biu2mem_wr_addr <= '0;
      bus.omap_biu2mem_wr_data <= '0;
      bus.omap_biu2mem_wr_strb <= '0;
    end else begin
      omap_biu_done <= 1'b0;

      if (beat_load) begin
        bus.omap_biu2mem_wr_vld  <= 1'b1;
        bus.omap_biu2mem_wr_addr <= addr_next;
        bus.omap_biu2mem_wr_data <= beat_data;
        bus.omap_biu2mem_wr_strb <= beat_strb;
        addr_next                <= addr_next + ADDR_W'(OMAP_BYTES_PER_BEAT);
      end else if (wr_fire) begin
        bus.omap_biu2mem_wr_vld  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            addr_next     <= {cfg_base_addr[ADDR_W-1:3], 3'b000};
            omap_biu_busy <= 1'b1;
            if (cfg_word_num != '0) begin
              word_cnt <= cfg_word_num;
              state    <= ST_RUN;
            end else begin
              omap_biu_done <= 1'b1;
              state         <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            word_cnt <= word_cnt - CNT_W'(1);
            if (last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (wr_fire) begin
            omap_biu_done <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          omap_biu_busy <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_omap_biu.sv
// Self-checking bench for omap_biu.
// A word-level model turns each layer's word list into the list of
// expected memory beats; a negedge compare process checks every write
// handshake, stall stability and ready-during-stall against it, and the
// directed tests pin literal beats, done timing and reset behaviour.
module tb_omap_biu;
  import acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [31:0] cfg_base_addr;
  logic [19:0] cfg_word_num;
  logic        busy;
  logic        done;

  omap_biu_if #(.ADDR_W(32)) bus ();

  omap_biu #(.ADDR_W(32), .CNT_W(20)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_word_num  (cfg_word_num),
    .bus           (bus),
    .omap_biu_busy (busy),
    .omap_biu_done (done)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // expected beats (written by main only)
  logic [31:0] exp_addr [64];
  logic [63:0] exp_data [64];
  logic [7:0]  exp_strb [64];
  int          exp_n = 0;

  // observations (written by the compare process only)
  logic [31:0] got_addr [64];
  logic [63:0] got_data [64];
  logic [7:0]  got_strb [64];
  int          wr_cnt = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          vld_cyc = 0;
  int          cycle = 0;
  int          last_hs_cycle = 0;
  int          done_cycle = 0;
  logic        took_word = 1'b0;
  logic        hold_pending = 1'b0;
  logic [31:0] h_addr;
  logic [63:0] h_data;
  logic [7:0]  h_strb;

  // word source (written by main only)
  logic [31:0] feed [8];
  int          feed_len = 0;
  int          feed_idx = 0;
  logic        feed_en = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Compare process: every handshaked beat must match the model in order;
  // a stalled beat must stay put and ready must be low meanwhile.
  always @(negedge clk) begin
    cycle = cycle + 1;
    took_word = 1'b0;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (bus.map_merger2omap_biu_vld && bus.map_merger2omap_biu_rdy) begin
        took_word = 1'b1;
        acc_cnt++;
      end
      if (bus.omap_biu2mem_wr_vld) vld_cyc++;
      if (hold_pending) begin
        check_output("hold_vld",  64'(bus.omap_biu2mem_wr_vld), 64'd1);
        check_output("hold_addr", 64'(bus.omap_biu2mem_wr_addr), 64'(h_addr));
        check_output("hold_data", bus.omap_biu2mem_wr_data, h_data);
        check_output("hold_strb", 64'(bus.omap_biu2mem_wr_strb), 64'(h_strb));
      end
      if (bus.omap_biu2mem_wr_vld && !bus.omap_biu2mem_wr_rdy)
        check_output("rdy_stall", 64'(bus.map_merger2omap_biu_rdy), 64'd0);
      if (bus.omap_biu2mem_wr_vld && bus.omap_biu2mem_wr_rdy) begin
        if (wr_cnt < exp_n) begin
          check_output("beat_addr", 64'(bus.omap_biu2mem_wr_addr), 64'(exp_addr[wr_cnt]));
          check_output("beat_data", bus.omap_biu2mem_wr_data, exp_data[wr_cnt]);
          check_output("beat_strb", 64'(bus.omap_biu2mem_wr_strb), 64'(exp_strb[wr_cnt]));
        end else begin
          check_output("extra_write", 64'(wr_cnt + 1), 64'(exp_n));
        end
        if (wr_cnt < 64) begin
          got_addr[wr_cnt] = bus.omap_biu2mem_wr_addr;
          got_data[wr_cnt] = bus.omap_biu2mem_wr_data;
          got_strb[wr_cnt] = bus.omap_biu2mem_wr_strb;
        end
        last_hs_cycle = cycle;
        wr_cnt++;
      end
      hold_pending = bus.omap_biu2mem_wr_vld && !bus.omap_biu2mem_wr_rdy;
      h_addr = bus.omap_biu2mem_wr_addr;
      h_data = bus.omap_biu2mem_wr_data;
      h_strb = bus.omap_biu2mem_wr_strb;
      if (done) begin
        done_cnt++;
        done_cycle = cycle;
      end
    end
  end

  // One clock step; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (took_word) feed_idx++;
    bus.map_merger2omap_biu_vld  = feed_en && (feed_idx < feed_len);
    bus.map_merger2omap_biu_data = (feed_idx < feed_len) ? feed[feed_idx] : 32'h0;
  endtask

  task automatic load_feed(input logic [31:0] w0, w1, w2, w3, input int n);
    feed[0] = w0; feed[1] = w1; feed[2] = w2; feed[3] = w3;
    feed_len = n;
    feed_idx = 0;
    feed_en  = 1'b1;
    bus.map_merger2omap_biu_vld  = (n > 0);
    bus.map_merger2omap_biu_data = w0;
  endtask

  // Model: words pair up as {later, earlier}; an odd tail goes alone
  // with strobe 0F; beat k lands at base + 8k (32-bit wrap).
  task automatic apply_stimulus(input logic [31:0] base, input int num);
    for (int i = 0; i < num; i += 2) begin
      exp_addr[exp_n] = base + 32'(8 * (i / 2));
      if (i + 1 < num) begin
        exp_data[exp_n] = {feed[i+1], feed[i]};
        exp_strb[exp_n] = 8'hFF;
      end else begin
        exp_data[exp_n] = {32'h0, feed[i]};
        exp_strb[exp_n] = 8'h0F;
      end
      exp_n++;
    end
    cfg_base_addr = base;
    cfg_word_num  = 20'(num);
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic run_until_done(input string name);
    int start_done;
    start_done = done_cnt;
    for (int i = 0; i < 200 && done_cnt == start_done; i++) tick();
    check_output({name, "_done"}, 64'(done_cnt - start_done), 64'd1);
    check_output({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  int s_wr, s_acc, s_done, s_vld;

  task automatic snap();
    s_wr = wr_cnt; s_acc = acc_cnt; s_done = done_cnt; s_vld = vld_cyc;
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    cfg_word_num = '0;
    bus.map_merger2omap_biu_vld  = 1'b0;
    bus.map_merger2omap_biu_data = '0;
    bus.omap_biu2mem_wr_rdy      = 1'b1;
    repeat (3) tick();
    check_output("rst_wr_vld", 64'(bus.omap_biu2mem_wr_vld), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_rdy", 64'(bus.map_merger2omap_biu_rdy), 64'd0);
    rst = 1'b0;
    tick();

    // 1: even layer, memory always ready
    $display("[TB] test 1: four words, wr_rdy high");
    snap();
    load_feed(32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 4);
    apply_stimulus(32'h1000, 4);
    check_output("t1_busy", 64'(busy), 64'd1);
    run_until_done("t1");
    check_output("t1_writes", 64'(wr_cnt - s_wr), 64'd2);
    check_output("t1_words", 64'(acc_cnt - s_acc), 64'd4);
    check_output("t1_b0_addr", 64'(got_addr[s_wr]), 64'h1000);
    check_output("t1_b0_data", got_data[s_wr], 64'hA1A1A1A1_A0A0A0A0);
    check_output("t1_b1_addr", 64'(got_addr[s_wr+1]), 64'h1008);
    check_output("t1_b1_data", got_data[s_wr+1], 64'hA3A3A3A3_A2A2A2A2);
    check_output("t1_b1_strb", 64'(got_strb[s_wr+1]), 64'hFF);
    check_output("t1_done_lat", 64'(done_cycle - last_hs_cycle), 64'd1);
    feed_en = 1'b0;
    tick();

    // 2: odd layer
    $display("[TB] test 2: three words");
    snap();
    load_feed(32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'h0, 3);
    apply_stimulus(32'h1000, 3);
    run_until_done("t2");
    check_output("t2_writes", 64'(wr_cnt - s_wr), 64'd2);
    check_output("t2_b0_data", got_data[s_wr], 64'hB1B1B1B1_B0B0B0B0);
    check_output("t2_b1_addr", 64'(got_addr[s_wr+1]), 64'h1008);
    check_output("t2_b1_data", got_data[s_wr+1], 64'h00000000_B2B2B2B2);
    check_output("t2_b1_strb", 64'(got_strb[s_wr+1]), 64'h0F);
    feed_en = 1'b0;
    tick();

    // 3: memory stall after the first beat appears
    $display("[TB] test 3: stalled memory");
    snap();
    bus.omap_biu2mem_wr_rdy = 1'b0;
    load_feed(32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 4);
    apply_stimulus(32'h1000, 4);
    for (int i = 0; i < 20 && !bus.omap_biu2mem_wr_vld; i++) tick();
    check_output("t3_first_beat", 64'(bus.omap_biu2mem_wr_vld), 64'd1);
    repeat (5) tick();
    check_output("t3_stall_words", 64'(acc_cnt - s_acc), 64'd2);
    bus.omap_biu2mem_wr_rdy = 1'b1;
    run_until_done("t3");
    check_output("t3_writes", 64'(wr_cnt - s_wr), 64'd2);
    check_output("t3_words", 64'(acc_cnt - s_acc), 64'd4);
    check_output("t3_b0_data", got_data[s_wr], 64'hC1C1C1C1_C0C0C0C0);
    feed_en = 1'b0;
    tick();

    // 4: empty layer; a start while in DONE is ignored
    $display("[TB] test 4: zero words");
    snap();
    apply_stimulus(32'h3000, 0);
    check_output("t4_busy", 64'(busy), 64'd1);
    check_output("t4_done", 64'(done), 64'd1);
    cfg_word_num = 20'd2;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check_output("t4_busy_end", 64'(busy), 64'd0);
    check_output("t4_done_end", 64'(done), 64'd0);
    tick();
    check_output("t4_start_in_done", 64'(busy), 64'd0);
    check_output("t4_done_pulses", 64'(done_cnt - s_done), 64'd1);
    check_output("t4_no_vld", 64'(vld_cyc - s_vld), 64'd0);

    // 5: surplus word and a start while busy
    $display("[TB] test 5: surplus word, start while busy");
    snap();
    load_feed(32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'h0, 3);
    apply_stimulus(32'h1000, 2);
    cfg_base_addr = 32'h4000;
    cfg_word_num  = 20'd8;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
    run_until_done("t5");
    repeat (3) tick();
    check_output("t5_words", 64'(acc_cnt - s_acc), 64'd2);
    check_output("t5_writes", 64'(wr_cnt - s_wr), 64'd1);
    check_output("t5_idle", 64'(busy), 64'd0);
    check_output("t5_b0_addr", 64'(got_addr[s_wr]), 64'h1000);
    feed_en = 1'b0;
    tick();

    // 6: reset mid-layer, then a fresh layer at a new base
    $display("[TB] test 6: reset mid-layer");
    snap();
    load_feed(32'hE0E0E0E0, 32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3, 4);
    apply_stimulus(32'h1000, 4);
    for (int i = 0; i < 20 && acc_cnt == s_acc; i++) tick();
    check_output("t6_one_word", 64'(acc_cnt - s_acc), 64'd1);
    rst = 1'b1;
    feed_en = 1'b0;
    bus.map_merger2omap_biu_vld = 1'b0;
    tick();
    check_output("t6_wr_vld", 64'(bus.omap_biu2mem_wr_vld), 64'd0);
    check_output("t6_wr_addr", 64'(bus.omap_biu2mem_wr_addr), 64'd0);
    check_output("t6_wr_data", bus.omap_biu2mem_wr_data, 64'd0);
    check_output("t6_wr_strb", 64'(bus.omap_biu2mem_wr_strb), 64'd0);
    check_output("t6_busy", 64'(busy), 64'd0);
    check_output("t6_done", 64'(done), 64'd0);
    check_output("t6_rdy", 64'(bus.map_merger2omap_biu_rdy), 64'd0);
    rst = 1'b0;
    exp_n = wr_cnt;
    tick();
    snap();
    load_feed(32'hF0F0F0F0, 32'hF1F1F1F1, 32'h0, 32'h0, 2);
    apply_stimulus(32'h2000, 2);
    run_until_done("t6");
    check_output("t6_writes", 64'(wr_cnt - s_wr), 64'd1);
    check_output("t6_b0_addr", 64'(got_addr[s_wr]), 64'h2000);
    check_output("t6_b0_data", got_data[s_wr], 64'hF1F1F1F1_F0F0F0F0);
    feed_en = 1'b0;
    tick();

    // 7: address wraps past the top of the address space
    $display("[TB] test 7: address wrap");
    snap();
    load_feed(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4);
    apply_stimulus(32'hFFFF_FFF8, 4);
    run_until_done("t7");
    check_output("t7_b0_addr", 64'(got_addr[s_wr]), 64'hFFFF_FFF8);
    check_output("t7_b1_addr", 64'(got_addr[s_wr+1]), 64'h0);
    feed_en = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
